// File: rtl/sw_align_sequencer_if.sv
// Host-side bundle for sw_align_sequencer: job config, target-base stream and score record.
// The host drives through 'master'; the sequencer drives through 'slave'.
interface sw_align_sequencer_if #(
    parameter int LOG_LENGTH  = 8,
    parameter int SCORE_WIDTH = 12,
    parameter int TGT_WIDTH   = 16
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [LOG_LENGTH-1:0]  cfg_qlen;

    logic                   tgt_valid;
    logic                   tgt_ready;
    logic [1:0]             tgt_base;
    logic                   tgt_last;

    logic                   res_valid;
    logic                   res_ready;
    logic [SCORE_WIDTH-1:0] res_score;
    logic [TGT_WIDTH-1:0]   res_tlen;
    logic [2:0]             res_flags;

    modport master (
        output cfg_valid, cfg_qlen, tgt_valid, tgt_base, tgt_last, res_ready,
        input  cfg_ready, tgt_ready, res_valid, res_score, res_tlen, res_flags
    );

    modport slave (
        input  cfg_valid, cfg_qlen, tgt_valid, tgt_base, tgt_last, res_ready,
        output cfg_ready, tgt_ready, res_valid, res_score, res_tlen, res_flags
    );
endinterface

// File: rtl/sw_align_sequencer.sv
// Job-level controller for the Smith-Waterman systolic array: clear, stream, drain, report.
// Optional macro SW_SCORE_UNBIAS_EN removes the 2^(SCORE_WIDTH-1) score bias (clamped at 0).
module sw_align_sequencer #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 128,
    parameter int LOG_LENGTH  = $clog2(LENGTH + 1),
    parameter int TGT_WIDTH   = 16,
    parameter int CLR_CYCLES  = 2,
    parameter int DRAIN_SLACK = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    sw_align_sequencer_if.slave     host,
    output logic                    arr_clr_n,
    output logic                    arr_en,
    output logic [1:0]              arr_data,
    output logic [LOG_LENGTH-1:0]   arr_select,
    input  logic [SCORE_WIDTH-1:0]  arr_result,
    input  logic                    arr_vld,
    output logic                    busy
);

    localparam int LIMIT_MAX = LENGTH + DRAIN_SLACK;
    localparam int DRAIN_W   = ($clog2(LIMIT_MAX + 1) > LOG_LENGTH + 1) ? $clog2(LIMIT_MAX + 1)
                                                                          : LOG_LENGTH + 1;
    localparam int CLR_W     = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [LOG_LENGTH-1:0] LENGTH_Q = LOG_LENGTH'(LENGTH);
    localparam logic [LOG_LENGTH:0]   LEN_EXT  = (LOG_LENGTH + 1)'(LENGTH);
    localparam logic [CLR_W-1:0]      CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    logic [CLR_W-1:0]       clr_cnt;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic [TGT_WIDTH-1:0]   tlen;
    logic                   started;
    logic                   bubble;
    logic                   cfg_err;

    logic                   cfg_ready_q;
    logic                   tgt_ready_q;
    logic                   res_valid_q;
    logic [SCORE_WIDTH-1:0] res_score_q;
    logic [TGT_WIDTH-1:0]   res_tlen_q;
    logic [2:0]             res_flags_q;

    logic                   qlen_bad;
    logic [DRAIN_W-1:0]     drain_next;
    logic [DRAIN_W-1:0]     drain_limit;
    logic [SCORE_WIDTH-1:0] score_cap;

    assign qlen_bad    = (host.cfg_qlen == '0) || ({1'b0, host.cfg_qlen} > LEN_EXT);
    assign drain_next  = drain_cnt + 1'b1;
    // arr_select holds the clamped qlen for the whole job; widened so the sum never wraps.
    assign drain_limit = DRAIN_W'(arr_select) + DRAIN_W'(DRAIN_SLACK);

`ifdef SW_SCORE_UNBIAS_EN
    localparam logic [SCORE_WIDTH-1:0] BIAS = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
    assign score_cap = (arr_result < BIAS) ? '0 : arr_result - BIAS;
`else
    assign score_cap = arr_result;
`endif

    assign host.cfg_ready = cfg_ready_q;
    assign host.tgt_ready = tgt_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_score = res_score_q;
    assign host.res_tlen  = res_tlen_q;
    assign host.res_flags = res_flags_q;
    assign busy           = (state != IDLE);

    // NOTE: every register here is updated with <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            drain_cnt   <= '0;
            tlen        <= '0;
            started     <= 1'b0;
            bubble      <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_ready_q <= 1'b0;
            tgt_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_score_q <= '0;
            res_tlen_q  <= '0;
            res_flags_q <= '0;
            arr_clr_n   <= 1'b0;
            arr_en      <= 1'b0;
            arr_data    <= '0;
            arr_select  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.cfg_valid && cfg_ready_q) begin
                        state       <= CLEAR;
                        cfg_ready_q <= 1'b0;
                        arr_clr_n   <= 1'b0;
                        arr_select  <= qlen_bad ? LENGTH_Q : host.cfg_qlen;
                        cfg_err     <= qlen_bad;
                        clr_cnt     <= '0;
                    end else begin
                        cfg_ready_q <= 1'b1;
                        arr_clr_n   <= 1'b1;
                    end
                end

                CLEAR: begin
                    tlen      <= '0;
                    started   <= 1'b0;
                    bubble    <= 1'b0;
                    drain_cnt <= '0;
                    if (clr_cnt == CLR_LAST) begin
                        state       <= STREAM;
                        arr_clr_n   <= 1'b1;
                        tgt_ready_q <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                STREAM: begin
                    if (host.tgt_valid) begin
                        arr_en   <= 1'b1;
                        arr_data <= host.tgt_base;
                        started  <= 1'b1;
                        if (!(&tlen)) tlen <= tlen + 1'b1;
                        if (host.tgt_last) begin
                            state       <= DRAIN;
                            tgt_ready_q <= 1'b0;
                        end
                    end else begin
                        arr_en <= 1'b0;
                        // Idle cycles before the first beat are not bubbles.
                        if (started) bubble <= 1'b1;
                    end
                end

                DRAIN: begin
                    arr_en    <= 1'b0;
                    drain_cnt <= drain_next;
                    if (arr_vld || (drain_next >= drain_limit)) begin
                        state       <= DONE;
                        res_valid_q <= 1'b1;
                        res_score_q <= score_cap;
                        res_tlen_q  <= tlen;
                        res_flags_q <= {~arr_vld, bubble, cfg_err};
                    end
                end

                DONE: begin
                    if (host.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_align_sequencer.sv
// Directed bench for sw_align_sequencer: table of jobs plus back-pressure and mid-job reset.
`timescale 1ns/1ps
module tb_sw_align_sequencer;

    localparam int SW  = 12;
    localparam int LEN = 128;
    localparam int LL  = 8;
    localparam int TW  = 16;
    localparam int NV  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sw_align_sequencer_if #(.LOG_LENGTH(LL), .SCORE_WIDTH(SW), .TGT_WIDTH(TW)) host ();

    logic          arr_clr_n;
    logic          arr_en;
    logic [1:0]    arr_data;
    logic [LL-1:0] arr_select;
    logic [SW-1:0] arr_result;
    logic          arr_vld;
    logic          busy;

    sw_align_sequencer #(
        .SCORE_WIDTH(SW), .LENGTH(LEN), .LOG_LENGTH(LL), .TGT_WIDTH(TW),
        .CLR_CYCLES(2), .DRAIN_SLACK(8)
    ) dut (
        .clk(clk), .rst(rst), .host(host),
        .arr_clr_n(arr_clr_n), .arr_en(arr_en), .arr_data(arr_data),
        .arr_select(arr_select), .arr_result(arr_result), .arr_vld(arr_vld),
        .busy(busy)
    );

    typedef struct {
        logic [LL-1:0] qlen;
        int            nb;
        int            gap_at;
        int            gap_len;
        int            vld_at;
        logic [SW-1:0] result;
        logic [LL-1:0] exp_sel;
        int            exp_drain;
        logic [SW-1:0] exp_raw;
        logic [TW-1:0] exp_tlen;
        logic [2:0]    exp_flags;
    } vec_t;

    vec_t vecs [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    int clr_lo, en_hi, first_hi, last_hi, idx, data_err, exp_k;

    always @(negedge clk) begin
        if (!arr_clr_n) clr_lo++;
        if (arr_en) begin
            if (en_hi == 0) first_hi = idx;
            last_hi = idx;
            en_hi++;
            if (arr_data !== 2'(exp_k)) data_err++;
            exp_k++;
        end
        idx++;
    end

    function automatic logic [SW-1:0] exp_score(input logic [SW-1:0] raw);
`ifdef SW_SCORE_UNBIAS_EN
        return (raw < 12'h800) ? 12'h000 : raw - 12'h800;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        clr_lo = 0; en_hi = 0; first_hi = 0; last_hi = 0; data_err = 0; exp_k = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arr_clr_n"},  32'(arr_clr_n), 0);
        check({tag, "_arr_en"},     32'(arr_en), 0);
        check({tag, "_arr_data"},   32'(arr_data), 0);
        check({tag, "_arr_select"}, 32'(arr_select), 0);
        check({tag, "_cfg_ready"},  32'(host.cfg_ready), 0);
        check({tag, "_tgt_ready"},  32'(host.tgt_ready), 0);
        check({tag, "_res_valid"},  32'(host.res_valid), 0);
        check({tag, "_res_score"},  32'(host.res_score), 0);
        check({tag, "_res_tlen"},   32'(host.res_tlen), 0);
        check({tag, "_res_flags"},  32'(host.res_flags), 0);
        check({tag, "_busy"},       32'(busy), 0);
    endtask

    task automatic send_cfg(input logic [LL-1:0] q);
        int w = 0;
        while (host.cfg_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check("cfg_ready_wait", 32'(host.cfg_ready), 1);
        mon_clear();
        host.cfg_valid = 1'b1;
        host.cfg_qlen  = q;
        @(negedge clk);
        host.cfg_valid = 1'b0;
        check("busy_after_cfg", 32'(busy), 1);
    endtask

    task automatic send_stream(input int nb, input int gap_at, input int gap_len);
        int w = 0;
        while (host.tgt_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check("tgt_ready_wait", 32'(host.tgt_ready), 1);
        for (int i = 0; i < nb; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin host.tgt_valid = 1'b0; @(negedge clk); end
            end
            host.tgt_valid = 1'b1;
            host.tgt_base  = 2'(i);
            host.tgt_last  = (i == nb - 1);
            @(negedge clk);
        end
        host.tgt_valid = 1'b0;
        host.tgt_last  = 1'b0;
    endtask

    task automatic run_drain(input int vld_at, input logic [SW-1:0] result, output int cycles);
        cycles = 0;
        for (int c = 0; c < 400 && host.res_valid !== 1'b1; c++) begin
            cycles++;
            arr_vld    = (cycles == vld_at);
            arr_result = (cycles == vld_at) ? result : SW'(32'h100 + cycles);
            @(negedge clk);
        end
        arr_vld = 1'b0;
        check("res_valid_after_drain", 32'(host.res_valid), 1);
    endtask

    task automatic check_job(input vec_t t, input int dc, input string tag);
        int gap_exp;
        gap_exp = (t.gap_at > 0 && t.gap_len > 0) ? t.gap_len : 0;
        check({tag, "_drain_cycles"}, 32'(dc), 32'(t.exp_drain));
        check({tag, "_res_score"},    32'(host.res_score), 32'(exp_score(t.exp_raw)));
        check({tag, "_res_tlen"},     32'(host.res_tlen), 32'(t.exp_tlen));
        check({tag, "_res_flags"},    32'(host.res_flags), 32'(t.exp_flags));
        check({tag, "_arr_select"},   32'(arr_select), 32'(t.exp_sel));
        check({tag, "_clr_low"},      32'(clr_lo), 2);
        check({tag, "_en_high"},      32'(en_hi), 32'(t.nb));
        check({tag, "_en_gap"},       32'(last_hi - first_hi + 1 - en_hi), 32'(gap_exp));
        check({tag, "_data_err"},     32'(data_err), 0);
    endtask

    task automatic handshake(input string tag);
        host.res_ready = 1'b1;
        @(negedge clk);
        host.res_ready = 1'b0;
        check({tag, "_res_valid_hs"}, 32'(host.res_valid), 0);
        check({tag, "_cfg_ready_hs"}, 32'(host.cfg_ready), 1);
        check({tag, "_busy_hs"},      32'(busy), 0);
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        int dc;
        send_cfg(t.qlen);
        send_stream(t.nb, t.gap_at, t.gap_len);
        run_drain(t.vld_at, t.result, dc);
        check_job(t, dc, tag);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        int   dc;
        int   seen;

        //           qlen     nb gap_at len vld  result   sel     drain raw      tlen    flags
        vecs[0] = '{8'd4,   6, -1, 0, 3, 12'h80A, 8'd4,   3,   12'h80A, 16'd6, 3'b000};
        vecs[1] = '{8'd8,   5,  3, 2, 2, 12'h7F0, 8'd8,   2,   12'h7F0, 16'd5, 3'b010};
        vecs[2] = '{8'd10,  3, -1, 0, 0, 12'h000, 8'd10,  18,  12'h112, 16'd3, 3'b100};
        vecs[3] = '{8'd0,   2, -1, 0, 1, 12'hFFF, 8'd128, 1,   12'hFFF, 16'd2, 3'b001};
        vecs[4] = '{8'd200, 1, -1, 0, 5, 12'h900, 8'd128, 5,   12'h900, 16'd1, 3'b001};
        vecs[5] = '{8'd1,   2, -1, 0, 9, 12'h055, 8'd1,   9,   12'h055, 16'd2, 3'b000};
        vecs[6] = '{8'd128, 4, -1, 0, 0, 12'h000, 8'd128, 136, 12'h188, 16'd4, 3'b100};
        vecs[7] = '{8'd5,   2,  0, 3, 2, 12'hC00, 8'd5,   2,   12'hC00, 16'd2, 3'b000};

        host.cfg_valid = 1'b0; host.cfg_qlen = '0;
        host.tgt_valid = 1'b0; host.tgt_base = '0; host.tgt_last = 1'b0;
        host.res_ready = 1'b0;
        arr_vld = 1'b0; arr_result = '0;
        mon_clear();
        idx = 0;

        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("cfg_ready_before_clk", 32'(host.cfg_ready), 0);
        @(negedge clk);
        check("cfg_ready_after_clk", 32'(host.cfg_ready), 1);
        check("arr_clr_n_idle", 32'(arr_clr_n), 1);

        for (int v = 0; v < NV; v++) run_vec(vecs[v], $sformatf("v%0d", v));

        // Back-pressure: record must hold and no config accepted until after the handshake.
        t = '{8'd4, 2, -1, 0, 1, 12'hA5A, 8'd4, 1, 12'hA5A, 16'd2, 3'b000};
        send_cfg(t.qlen);
        send_stream(t.nb, t.gap_at, t.gap_len);
        run_drain(t.vld_at, t.result, dc);
        check_job(t, dc, "bp");
        host.cfg_valid = 1'b1;
        host.cfg_qlen  = 8'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(host.res_valid), 1);
            check("bp_hold_score", 32'(host.res_score), 32'(exp_score(12'hA5A)));
            check("bp_hold_tlen",  32'(host.res_tlen), 2);
            check("bp_hold_flags", 32'(host.res_flags), 0);
            check("bp_hold_cfg_ready", 32'(host.cfg_ready), 0);
        end
        mon_clear();
        host.res_ready = 1'b1;
        @(negedge clk);
        host.res_ready = 1'b0;
        check("bp_res_valid_hs", 32'(host.res_valid), 0);
        check("bp_cfg_ready_hs", 32'(host.cfg_ready), 1);
        @(negedge clk);
        host.cfg_valid = 1'b0;
        check("bp_next_busy",      32'(busy), 1);
        check("bp_next_clr_n",     32'(arr_clr_n), 0);
        check("bp_next_cfg_ready", 32'(host.cfg_ready), 0);
        t = '{8'd3, 3, -1, 0, 2, 12'h801, 8'd3, 2, 12'h801, 16'd3, 3'b000};
        send_stream(t.nb, t.gap_at, t.gap_len);
        run_drain(t.vld_at, t.result, dc);
        check_job(t, dc, "bp2");
        handshake("bp2");

        // Asynchronous reset after three streamed beats discards the job.
        send_cfg(8'd6);
        begin
            int w = 0;
            while (host.tgt_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        end
        for (int i = 0; i < 3; i++) begin
            host.tgt_valid = 1'b1;
            host.tgt_base  = 2'(i);
            host.tgt_last  = 1'b0;
            @(negedge clk);
        end
        host.tgt_valid = 1'b0;
        check("mid_arr_en_before_rst", 32'(arr_en), 1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (host.res_valid === 1'b1) seen++;
        end
        check("mid_no_record", 32'(seen), 0);
        t = '{8'd3, 2, -1, 0, 1, 12'h900, 8'd3, 1, 12'h900, 16'd2, 3'b000};
        run_vec(t, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
